bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_if.sv | 23 ++
 rtl/bin2bcd_seq.sv | 108 ++++++++++
 2 files changed

// File: rtl/bin2bcd_seq_if.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq_if
// Request/result bundle for the sequential binary-to-BCD converter.
//   start : conversion request (requester -> converter)
//   bin   : unsigned binary operand, WIDTH bits (requester -> converter)
//   busy  : conversion in progress or completing (converter -> requester)
//   done  : one-cycle pulse, bcd holds a fresh result (converter -> requester)
//   bcd   : packed BCD result, 4*DIGITS bits, digit 0 = units (converter -> requester)
// Modports: master = requester side, slave = converter side.
// -----------------------------------------------------------------------------
interface bin2bcd_seq_if #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [WIDTH-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble (shift-add-3) binary-to-BCD converter.
// One conversion takes WIDTH shift cycles plus one DONE cycle; with start held
// high a new conversion begins every WIDTH+2 cycles.
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bin2bcd_seq_if.slave (start, bin in; busy, done, bcd out)
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module bin2bcd_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  bin2bcd_seq_if.slave  bus
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  sh_q, sh_nxt;
  logic [BCD_W-1:0]  scr_q, scr_nxt;
  logic [BCD_W-1:0]  bcd_q, bcd_nxt;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  logic              busy_q, done_q;

  // Add 3 to every digit that is 5 or more, so that the following left shift
  // carries into the next decimal digit exactly when the doubled value is >= 10.
  function automatic logic [BCD_W-1:0] add3_digits(input logic [BCD_W-1:0] s);
    logic [BCD_W-1:0] r;
    r = s;
    for (int k = 0; k < DIGITS; k++) begin
      if (s[4*k +: 4] >= 4'd5) r[4*k +: 4] = s[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  always_comb begin
    state_nxt = state;
    sh_nxt    = sh_q;
    scr_nxt   = scr_q;
    cnt_nxt   = cnt_q;
    bcd_nxt   = bcd_q;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = SHIFT;
          sh_nxt    = bus.bin;
          scr_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      SHIFT: begin
        {scr_nxt, sh_nxt} = {add3_digits(scr_q), sh_q} << 1;
        cnt_nxt           = cnt_q + CNT_W'(1);
        // The last shift's result goes straight to the output register.
        if (cnt_q == LAST) begin
          state_nxt = DONE;
          bcd_nxt   = scr_nxt;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sh_q   <= '0;
      scr_q  <= '0;
      cnt_q  <= '0;
      bcd_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      sh_q   <= sh_nxt;
      scr_q  <= scr_nxt;
      cnt_q  <= cnt_nxt;
      bcd_q  <= bcd_nxt;
      // Status flags are registered from the next state so they track the
      // FSM cycle-for-cycle without any combinational path to the outputs.
      busy_q <= (state_nxt != IDLE);
      done_q <= (state_nxt == DONE);
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.bcd  = bcd_q;

endmodule
